// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of the streaming FFT: issues a config word, gates FFT_LEN
// samples with a last marker, waits for the FFT to drain and keeps sticky error/status.
module fft_frame_ctrl #(
    parameter int FFT_LEN = 1024,
    parameter int DATA_W  = 16,
    parameter int CFG_W   = 16,
    parameter int TIMEOUT = 8192
) (
    input  logic              i_aclk,
    input  logic              i_areset,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic [CFG_W-1:0]  i_cfg_word,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_valid,
    output logic [DATA_W-1:0] o_fft_in_data,
    output logic              o_fft_in_valid,
    output logic              o_fft_in_last,
    input  logic              i_fft_in_ready,
    output logic [CFG_W-1:0]  o_fft_cfg_data,
    output logic              o_fft_cfg_valid,
    input  logic              i_fft_out_valid,
    input  logic              i_fft_out_last,
    input  logic [2:0]        i_fft_alm,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [15:0]       o_frame_cnt,
    output logic [3:0]        o_err,
    input  logic              i_err_clr
);

    localparam int CNT_W = $clog2(FFT_LEN) + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LEN_C      = CNT_W'(FFT_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(FFT_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LAST_C  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CFG, FILL, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [DATA_W-1:0]  inData_q, inData_d;
    logic               inValid_q, inValid_d;
    logic               inLast_q, inLast_d;
    logic [CFG_W-1:0]   cfgData_q, cfgData_d;
    logic               cfgValid_q, cfgValid_d;
    logic               frameDone_q, frameDone_d;
    logic [15:0]        frameCnt_q, frameCnt_d;
    logic [3:0]         err_q, err_d;
    logic [3:0]         errSet;
    logic               consume;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        inData_d  = inData_q;
        inValid_d = inValid_q;
        inLast_d  = inLast_q;
        errSet    = '0;
        consume   = inValid_q && i_fft_in_ready;

        case (state_q)
            IDLE: begin
                if (i_start) state_d = CFG;
            end
            CFG: begin
                cnt_d   = '0;
                state_d = FILL;
            end
            FILL: begin
                if (consume) begin
                    inValid_d = 1'b0;
                    inLast_d  = 1'b0;
                end
                // Once the whole frame is counted in, extra samples are dropped silently.
                if (i_adc_valid && (cnt_q < LEN_C)) begin
                    if (!inValid_q || consume) begin
                        inData_d  = i_adc_data;
                        inValid_d = 1'b1;
                        inLast_d  = (cnt_q == LAST_IDX_C);
                        cnt_d     = cnt_q + CNT_W'(1);
                    end else begin
                        errSet[0] = 1'b1;
                    end
                end
                if (consume && inLast_q) begin
                    state_d = DRAIN;
                    wd_d    = '0;
                end
            end
            DRAIN: begin
                wd_d = wd_q + WD_W'(1);
                if (i_fft_out_valid && i_fft_out_last) begin
                    state_d = DONE;
                end else if (wd_q == WD_LAST_C) begin
                    errSet[1] = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                state_d = i_continuous ? CFG : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            inValid_d = 1'b0;
            inLast_d  = 1'b0;
            errSet[3] = 1'b1;
        end
        if ((i_fft_alm != 3'b000) && (state_q != IDLE)) errSet[2] = 1'b1;

        // Pulsed outputs are registered on entry so they line up with the CFG/DONE cycle.
        cfgValid_d  = (state_d == CFG);
        cfgData_d   = cfgValid_d ? i_cfg_word : cfgData_q;
        frameDone_d = (state_d == DONE);
        frameCnt_d  = frameDone_d ? frameCnt_q + 16'd1 : frameCnt_q;
        err_d       = (i_err_clr ? 4'b0000 : err_q) | errSet;
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            inData_q    <= '0;
            inValid_q   <= 1'b0;
            inLast_q    <= 1'b0;
            cfgData_q   <= '0;
            cfgValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            inData_q    <= inData_d;
            inValid_q   <= inValid_d;
            inLast_q    <= inLast_d;
            cfgData_q   <= cfgData_d;
            cfgValid_q  <= cfgValid_d;
            frameDone_q <= frameDone_d;
            frameCnt_q  <= frameCnt_d;
            err_q       <= err_d;
        end
    end

    assign o_fft_in_data   = inData_q;
    assign o_fft_in_valid  = inValid_q;
    assign o_fft_in_last   = inLast_q;
    assign o_fft_cfg_data  = cfgData_q;
    assign o_fft_cfg_valid = cfgValid_q;
    assign o_busy          = (state_q != IDLE);
    assign o_frame_done    = frameDone_q;
    assign o_frame_cnt     = frameCnt_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl using a short frame and watchdog so every
// scenario (single, backpressure, continuous, watchdog, abort, alarm, reset) stays brief.
module tb_fft_frame_ctrl;

    localparam int LEN = 8;
    localparam int TO  = 16;

    logic        clk;
    logic        rst;
    logic        i_start, i_continuous, i_abort, i_adc_valid, i_fft_in_ready;
    logic [15:0] i_cfg_word, i_adc_data;
    logic [15:0] o_fft_in_data, o_fft_cfg_data, o_frame_cnt;
    logic        o_fft_in_valid, o_fft_in_last, o_fft_cfg_valid;
    logic        i_fft_out_valid, i_fft_out_last;
    logic [2:0]  i_fft_alm;
    logic        o_busy, o_frame_done, i_err_clr;
    logic [3:0]  o_err;

    int tests  = 0;
    int failed = 0;
    bit readyToggle = 1'b0;

    // Stream monitor totals; the main sequence snapshots them to measure each frame.
    int          beats = 0;
    int          lastCnt = 0;
    int          lastBeatIdx = 0;
    int          doneCnt = 0;
    int          cfgCnt = 0;
    int          dupErr = 0;
    logic [15:0] prevData = '0;
    bit          havePrev = 1'b0;

    int bBase, lBase, dBase, cBase;

    fft_frame_ctrl #(.FFT_LEN(LEN), .DATA_W(16), .CFG_W(16), .TIMEOUT(TO)) dut (
        .i_aclk(clk), .i_areset(rst),
        .i_start(i_start), .i_continuous(i_continuous), .i_abort(i_abort),
        .i_cfg_word(i_cfg_word), .i_adc_data(i_adc_data), .i_adc_valid(i_adc_valid),
        .o_fft_in_data(o_fft_in_data), .o_fft_in_valid(o_fft_in_valid),
        .o_fft_in_last(o_fft_in_last), .i_fft_in_ready(i_fft_in_ready),
        .o_fft_cfg_data(o_fft_cfg_data), .o_fft_cfg_valid(o_fft_cfg_valid),
        .i_fft_out_valid(i_fft_out_valid), .i_fft_out_last(i_fft_out_last),
        .i_fft_alm(i_fft_alm), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_cnt(o_frame_cnt), .o_err(o_err), .i_err_clr(i_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC ramp and FFT ready pattern change just after each rising edge.
    initial begin
        i_adc_data     = '0;
        i_fft_in_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_adc_data     = i_adc_data + 16'd1;
            i_fft_in_ready = readyToggle ? ~i_fft_in_ready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_fft_in_valid && i_fft_in_ready) begin
                    beats++;
                    if (o_fft_in_last) begin
                        lastCnt++;
                        lastBeatIdx = beats;
                    end
                    if (havePrev && (o_fft_in_data <= prevData)) dupErr++;
                    prevData = o_fft_in_data;
                    havePrev = 1'b1;
                end
                if (o_frame_done) doneCnt++;
                if (o_fft_cfg_valid) cfgCnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Pulse i_start for one cycle; afterwards the DUT is in CFG.
    task automatic applyStimulus(input logic [15:0] cfg);
        i_cfg_word = cfg;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic waitLast(input int base, input int limit);
        int n = 0;
        while (lastCnt == base && n < limit) begin
            tick();
            n++;
        end
        checkOutput("lastBeatSeen", 32'(lastCnt != base), 32'd1);
    endtask

    task automatic waitBeats(input int base, input int count, input int limit);
        int n = 0;
        while ((beats - base) < count && n < limit) begin
            tick();
            n++;
        end
        checkOutput("beatsReached", 32'((beats - base) >= count), 32'd1);
    endtask

    // Called in the last-beat cycle; returns in the DONE cycle.
    task automatic drainOut(input int lat);
        tick();
        repeat (lat) tick();
        i_fft_out_valid = 1'b1;
        i_fft_out_last  = 1'b1;
        tick();
        i_fft_out_valid = 1'b0;
        i_fft_out_last  = 1'b0;
    endtask

    task automatic clearErr();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        tick();
        checkOutput("errCleared", 32'(o_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 0; i_continuous = 0; i_abort = 0; i_adc_valid = 0;
        i_cfg_word = '0; i_fft_out_valid = 0; i_fft_out_last = 0;
        i_fft_alm = '0; i_err_clr = 0;
        tick(); tick();

        // Reset values
        checkOutput("rstBusy",     32'(o_busy), 32'h0);
        checkOutput("rstInValid",  32'(o_fft_in_valid), 32'h0);
        checkOutput("rstCfgValid", 32'(o_fft_cfg_valid), 32'h0);
        checkOutput("rstFrameCnt", 32'(o_frame_cnt), 32'h0);
        checkOutput("rstErr",      32'(o_err), 32'h0);
        rst = 1'b0;
        i_adc_valid = 1'b1;
        tick(); tick();
        checkOutput("idleNoOverflow", 32'(o_err), 32'h0);

        // Single frame with timing of the first beats
        bBase = beats; lBase = lastCnt; dBase = doneCnt;
        applyStimulus(16'hA5A5);
        checkOutput("cfgValidPulse", 32'(o_fft_cfg_valid), 32'h1);
        checkOutput("cfgData",       32'(o_fft_cfg_data), 32'hA5A5);
        checkOutput("busyInCfg",     32'(o_busy), 32'h1);
        tick();
        checkOutput("cfgValidOneCycle", 32'(o_fft_cfg_valid), 32'h0);
        checkOutput("noBeatYet",        32'(o_fft_in_valid), 32'h0);
        tick();
        checkOutput("firstBeatLatency", 32'(o_fft_in_valid), 32'h1);
        waitLast(lBase, 100);
        drainOut(5);
        checkOutput("frameDone1", 32'(o_frame_done), 32'h1);
        checkOutput("frameCnt1",  32'(o_frame_cnt), 32'd1);
        tick();
        checkOutput("donePulseEnds", 32'(o_frame_done), 32'h0);
        checkOutput("idleAfter1",    32'(o_busy), 32'h0);
        checkOutput("beats1",        32'(beats - bBase), 32'(LEN));
        checkOutput("lastPos1",      32'(lastBeatIdx - bBase), 32'(LEN));
        checkOutput("lastCount1",    32'(lastCnt - lBase), 32'd1);
        checkOutput("doneCount1",    32'(doneCnt - dBase), 32'd1);
        checkOutput("err1",          32'(o_err), 32'h0);

        // Backpressure: ready toggles, valid every cycle
        readyToggle = 1'b1;
        bBase = beats; lBase = lastCnt;
        applyStimulus(16'h0B0B);
        waitLast(lBase, 100);
        drainOut(2);
        checkOutput("frameCnt2", 32'(o_frame_cnt), 32'd2);
        tick();
        checkOutput("overflowFlag", 32'(o_err[0]), 32'h1);
        checkOutput("beats2",       32'(beats - bBase), 32'(LEN));
        checkOutput("lastPos2",     32'(lastBeatIdx - bBase), 32'(LEN));
        checkOutput("noDupOrder",   32'(dupErr), 32'd0);
        readyToggle = 1'b0;
        tick(); tick();
        clearErr();

        // Continuous mode, three frames, new config word per frame
        i_continuous = 1'b1;
        bBase = beats; cBase = cfgCnt;
        applyStimulus(16'h1111);
        checkOutput("contCfg0", 32'(o_fft_cfg_data), 32'h1111);
        for (int f = 0; f < 3; f++) begin
            lBase = lastCnt;
            waitLast(lBase, 100);
            tick();
            i_cfg_word = 16'h1111 * 16'(f + 2);
            if (f == 2) i_continuous = 1'b0;
            i_fft_out_valid = 1'b1;
            i_fft_out_last  = 1'b1;
            tick();
            i_fft_out_valid = 1'b0;
            i_fft_out_last  = 1'b0;
            checkOutput("contDone", 32'(o_frame_done), 32'h1);
            tick();
            if (f < 2) begin
                checkOutput("cfgAfterDone",  32'(o_fft_cfg_valid), 32'h1);
                checkOutput("contCfgData",   32'(o_fft_cfg_data), 32'(16'h1111 * 16'(f + 2)));
            end else begin
                checkOutput("contStops", 32'(o_busy), 32'h0);
            end
        end
        checkOutput("contFrameCnt", 32'(o_frame_cnt), 32'd5);
        checkOutput("contCfgCount", 32'(cfgCnt - cBase), 32'd3);
        checkOutput("contBeats",    32'(beats - bBase), 32'(3 * LEN));
        checkOutput("contErr",      32'(o_err), 32'h0);

        // Watchdog: the FFT never finishes
        lBase = lastCnt; dBase = doneCnt;
        applyStimulus(16'h2222);
        waitLast(lBase, 100);
        repeat (TO) tick();
        checkOutput("wdStillBusy", 32'(o_busy), 32'h1);
        checkOutput("wdNotYet",    32'(o_err[1]), 32'h0);
        tick();
        checkOutput("wdIdle",      32'(o_busy), 32'h0);
        checkOutput("wdErr",       32'(o_err[1]), 32'h1);
        checkOutput("wdNoDone",    32'(doneCnt - dBase), 32'd0);
        checkOutput("wdFrameCnt",  32'(o_frame_cnt), 32'd5);
        clearErr();

        // Abort in IDLE does nothing
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checkOutput("abortIdleNoErr", 32'(o_err), 32'h0);

        // Abort mid-fill, then a clean frame
        bBase = beats;
        applyStimulus(16'h3333);
        waitBeats(bBase, LEN / 2, 100);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checkOutput("abortBusy",    32'(o_busy), 32'h0);
        checkOutput("abortInValid", 32'(o_fft_in_valid), 32'h0);
        checkOutput("abortInLast",  32'(o_fft_in_last), 32'h0);
        checkOutput("abortErr",     32'(o_err[3]), 32'h1);
        clearErr();
        bBase = beats; lBase = lastCnt;
        applyStimulus(16'h4444);
        waitLast(lBase, 100);
        drainOut(3);
        checkOutput("postAbortCnt", 32'(o_frame_cnt), 32'd6);
        tick();
        checkOutput("postAbortBeats", 32'(beats - bBase), 32'(LEN));
        checkOutput("postAbortLast",  32'(lastBeatIdx - bBase), 32'(LEN));
        checkOutput("postAbortErr",   32'(o_err), 32'h0);

        // Alarm sticky bit and clear/set collision
        lBase = lastCnt;
        applyStimulus(16'h5555);
        tick(); tick();
        i_fft_alm = 3'b010;
        tick();
        i_fft_alm = 3'b000;
        checkOutput("alarmSet", 32'(o_err), 32'h4);
        tick(); tick();
        checkOutput("alarmSticky", 32'(o_err[2]), 32'h1);
        i_err_clr = 1'b1;
        i_fft_alm = 3'b010;
        tick();
        i_err_clr = 1'b0;
        i_fft_alm = 3'b000;
        checkOutput("setWinsClear", 32'(o_err[2]), 32'h1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        checkOutput("alarmCleared", 32'(o_err), 32'h0);
        waitLast(lBase, 100);
        drainOut(1);
        checkOutput("alarmFrameCnt", 32'(o_frame_cnt), 32'd7);
        tick();

        // Asynchronous reset in the middle of FILL
        applyStimulus(16'h6666);
        tick(); tick(); tick();
        checkOutput("preRstInValid", 32'(o_fft_in_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy",     32'(o_busy), 32'h0);
        checkOutput("midRstInValid",  32'(o_fft_in_valid), 32'h0);
        checkOutput("midRstInData",   32'(o_fft_in_data), 32'h0);
        checkOutput("midRstCfgData",  32'(o_fft_cfg_data), 32'h0);
        checkOutput("midRstFrameCnt", 32'(o_frame_cnt), 32'h0);
        checkOutput("midRstErr",      32'(o_err), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
